// File: rtl/link_pkg.sv
// Shared definitions for the inter-board move link: FSM state encoding and the
// reserved ACK code, so the game FSM and the bench agree on the same value.
package link_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSendMove,
    StWaitTx,
    StWaitAck,
    StSendAck,
    StAckGap,
    StError
  } link_state_t;

  localparam logic [7:0] ACK_BYTE_DEFAULT = 8'hFF;

endpackage

// File: rtl/link_timer.sv
// Loadable down-counter shared by the frame gap and the ACK wait.
// expired marks the final cycle before the count reaches 0.
module link_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic             expired
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A load of N therefore expires exactly N cycles after the load cycle.
  assign expired = (count_q == Width'(1));

endmodule

// File: rtl/move_link_ctrl.sv
// Reliable-delivery controller between the game FSM and the UART pair: sends
// local moves with retransmission, ACKs peer moves and forwards each once.
module move_link_ctrl
  import link_pkg::*;
#(
  parameter int unsigned        PKT_LEN     = 8,
  parameter int unsigned        FRAME_CLKS  = 67_710,
  parameter int unsigned        ACK_TIMEOUT = 65_000_000,
  parameter int unsigned        MAX_RETRIES = 3,
  parameter logic [PKT_LEN-1:0] ACK_BYTE    = PKT_LEN'(ACK_BYTE_DEFAULT)
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               move_valid,
  input  logic [PKT_LEN-1:0] move_in,
  input  logic               rx_ready,
  input  logic [PKT_LEN-1:0] rx_data,
  output logic               tx_trigger,
  output logic [PKT_LEN-1:0] tx_data,
  output logic               peer_move_valid,
  output logic [PKT_LEN-1:0] peer_move,
  output logic               link_busy,
  output logic               link_error
);

  localparam int unsigned TimerW = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned RetryW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  link_state_t        state_q, state_d;
  logic [PKT_LEN-1:0] tx_data_q, tx_data_d;
  logic [PKT_LEN-1:0] peer_move_q, peer_move_d;
  logic [PKT_LEN-1:0] pend_q, pend_d;
  logic               pend_full_q, pend_full_d;
  logic [RetryW-1:0]  retry_q, retry_d;
  logic               expect_q, expect_d;
  logic               tmr_load;
  logic [TimerW-1:0]  tmr_val;
  logic               tmr_expired;

  link_timer #(
    .Width(TimerW)
  ) u_timer (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .load    (tmr_load),
    .load_val(tmr_val),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d     = state_q;
    tx_data_d   = tx_data_q;
    peer_move_d = peer_move_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    retry_d     = retry_q;
    expect_d    = expect_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;

    unique case (state_q)
      StIdle: begin
        // A peer byte wins over a local move; the move waits in the slot.
        if (rx_ready && rx_data != ACK_BYTE) begin
          state_d   = StSendAck;
          tx_data_d = ACK_BYTE;
          if (expect_q) peer_move_d = rx_data;
          if (move_valid && !pend_full_q) begin
            pend_d      = move_in;
            pend_full_d = 1'b1;
          end
        end else if (pend_full_q) begin
          state_d     = StSendMove;
          tx_data_d   = pend_q;
          retry_d     = '0;
          pend_full_d = move_valid;
          if (move_valid) pend_d = move_in;
        end else if (move_valid) begin
          state_d   = StSendMove;
          tx_data_d = move_in;
          retry_d   = '0;
        end
      end
      StSendMove: begin
        tmr_load = 1'b1;
        tmr_val  = TimerW'(FRAME_CLKS);
        state_d  = StWaitTx;
      end
      StWaitTx: begin
        if (tmr_expired) begin
          tmr_load = 1'b1;
          tmr_val  = TimerW'(ACK_TIMEOUT);
          state_d  = StWaitAck;
        end
      end
      StWaitAck: begin
        if (rx_ready && rx_data == ACK_BYTE) begin
          expect_d = 1'b1;
          state_d  = StIdle;
        end else if (tmr_expired) begin
          if (retry_q < RetryW'(MAX_RETRIES)) begin
            retry_d = retry_q + RetryW'(1);
            state_d = StSendMove;
          end else begin
            state_d = StError;
          end
        end
      end
      StSendAck: begin
        tmr_load = 1'b1;
        tmr_val  = TimerW'(FRAME_CLKS);
        expect_d = 1'b0;
        state_d  = StAckGap;
      end
      StAckGap: begin
        if (tmr_expired) state_d = StIdle;
      end
      StError: begin
        if (move_valid) begin
          state_d   = StSendMove;
          tx_data_d = move_in;
          retry_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (move_valid && !pend_full_q && state_q != StIdle && state_q != StError) begin
      pend_d      = move_in;
      pend_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= StIdle;
      tx_data_q   <= '0;
      peer_move_q <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      retry_q     <= '0;
      expect_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      tx_data_q   <= tx_data_d;
      peer_move_q <= peer_move_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      retry_q     <= retry_d;
      expect_q    <= expect_d;
    end
  end

  assign tx_trigger      = (state_q == StSendMove) || (state_q == StSendAck);
  assign tx_data         = tx_data_q;
  assign peer_move_valid = (state_q == StSendAck) && expect_q;
  assign peer_move       = peer_move_q;
  assign link_busy       = (state_q != StIdle) && (state_q != StError);
  assign link_error      = (state_q == StError);

endmodule

// File: tb/tb_move_link_ctrl.sv
// Self-checking bench for move_link_ctrl: vector table for the single-cycle
// behaviour, hand sequences for retries, collision and reset.
module tb_move_link_ctrl;
  import link_pkg::*;

  localparam int unsigned F = 20;
  localparam int unsigned T = 100;
  localparam int unsigned M = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mv = 1'b0;
  logic [7:0] mi = '0;
  logic       rr = 1'b0;
  logic [7:0] rd = '0;
  logic       tx_trigger, peer_move_valid, link_busy, link_error;
  logic [7:0] tx_data, peer_move;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  move_link_ctrl #(
    .PKT_LEN    (8),
    .FRAME_CLKS (F),
    .ACK_TIMEOUT(T),
    .MAX_RETRIES(M),
    .ACK_BYTE   (ACK_BYTE_DEFAULT)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .move_valid     (mv),
    .move_in        (mi),
    .rx_ready       (rr),
    .rx_data        (rd),
    .tx_trigger     (tx_trigger),
    .tx_data        (tx_data),
    .peer_move_valid(peer_move_valid),
    .peer_move      (peer_move),
    .link_busy      (link_busy),
    .link_error     (link_error)
  );

  typedef struct {
    int         pre;
    logic       mv;
    logic [7:0] mi;
    logic       rr;
    logic [7:0] rd;
    logic       tt;
    logic [7:0] td;
    logic       pv;
    logic [7:0] pm;
    logic       busy;
    logic       err;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(int pre, logic v_mv, logic [7:0] v_mi, logic v_rr, logic [7:0] v_rd,
                              logic tt, logic [7:0] td, logic pv, logic [7:0] pm, logic busy,
                              logic err);
    vec_t v;
    v.pre = pre; v.mv = v_mv; v.mi = v_mi; v.rr = v_rr; v.rd = v_rd;
    v.tt = tt; v.td = td; v.pv = pv; v.pm = pm; v.busy = busy; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until tx_trigger is seen or the budget runs out; n = steps taken.
  task automatic wait_trig(input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tx_trigger && n < budget);
  endtask

  initial begin
    int n;
    int trig;

    //              pre mv mi     rr rd     tt td     pv pm     busy err
    vecs[0]  = mk(0,  0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0);  // reset state
    vecs[1]  = mk(0,  0, 8'h00, 1, 8'h44, 1, 8'hFF, 1, 8'h44, 1, 0);  // peer move
    vecs[2]  = mk(0,  0, 8'h00, 0, 8'h00, 0, 8'hFF, 0, 8'h44, 1, 0);
    vecs[3]  = mk(18, 0, 8'h00, 0, 8'h00, 0, 8'hFF, 0, 8'h44, 1, 0);  // last ACK_GAP cycle
    vecs[4]  = mk(0,  0, 8'h00, 0, 8'h00, 0, 8'hFF, 0, 8'h44, 0, 0);  // back in IDLE
    vecs[5]  = mk(0,  0, 8'h00, 1, 8'h44, 1, 8'hFF, 0, 8'h44, 1, 0);  // duplicate re-ACK
    vecs[6]  = mk(0,  0, 8'h00, 0, 8'h00, 0, 8'hFF, 0, 8'h44, 1, 0);
    vecs[7]  = mk(19, 0, 8'h00, 0, 8'h00, 0, 8'hFF, 0, 8'h44, 0, 0);
    vecs[8]  = mk(0,  0, 8'h00, 1, 8'hFF, 0, 8'hFF, 0, 8'h44, 0, 0);  // stray ACK ignored
    vecs[9]  = mk(0,  1, 8'h35, 0, 8'h00, 1, 8'h35, 0, 8'h44, 1, 0);  // clean send
    vecs[10] = mk(19, 0, 8'h00, 0, 8'h00, 0, 8'h35, 0, 8'h44, 1, 0);  // last WAIT_TX cycle
    vecs[11] = mk(0,  0, 8'h00, 0, 8'h00, 0, 8'h35, 0, 8'h44, 1, 0);  // WAIT_ACK
    vecs[12] = mk(0,  0, 8'h00, 1, 8'hFF, 0, 8'h35, 0, 8'h44, 0, 0);  // ACK -> IDLE
    vecs[13] = mk(0,  0, 8'h00, 1, 8'h07, 1, 8'hFF, 1, 8'h07, 1, 0);  // new peer move forwarded
    vecs[14] = mk(19, 0, 8'h00, 0, 8'h00, 0, 8'hFF, 0, 8'h07, 1, 0);
    vecs[15] = mk(0,  0, 8'h00, 0, 8'h00, 0, 8'hFF, 0, 8'h07, 0, 0);

    repeat (2) step();
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      repeat (vecs[i].pre) step();
      mv = vecs[i].mv; mi = vecs[i].mi; rr = vecs[i].rr; rd = vecs[i].rd;
      step();
      mv = 1'b0; rr = 1'b0;
      chk($sformatf("vec%0d.tx_trigger", i), 32'(tx_trigger), 32'(vecs[i].tt));
      chk($sformatf("vec%0d.tx_data", i), 32'(tx_data), 32'(vecs[i].td));
      chk($sformatf("vec%0d.peer_move_valid", i), 32'(peer_move_valid), 32'(vecs[i].pv));
      chk($sformatf("vec%0d.peer_move", i), 32'(peer_move), 32'(vecs[i].pm));
      chk($sformatf("vec%0d.link_busy", i), 32'(link_busy), 32'(vecs[i].busy));
      chk($sformatf("vec%0d.link_error", i), 32'(link_error), 32'(vecs[i].err));
    end

    // Retries exhausted: three sends of 8'h12, 121 cycles apart, then sticky error.
    mv = 1'b1; mi = 8'h12;
    step();
    mv = 1'b0;
    chk("retry.first_trigger", 32'(tx_trigger), 32'd1);
    chk("retry.first_data", 32'(tx_data), 32'h12);
    for (int k = 1; k <= 2; k++) begin
      wait_trig(200, n);
      chk($sformatf("retry.spacing%0d", k), 32'(n), 32'd121);
      chk($sformatf("retry.data%0d", k), 32'(tx_data), 32'h12);
    end
    n = 0;
    do begin
      step();
      n++;
    end while (!link_error && n < 200);
    chk("retry.cycles_to_error", 32'(n), 32'd121);
    chk("retry.busy_in_error", 32'(link_busy), 32'd0);
    trig = 0;
    n = 0;
    for (int c = 0; c < 50; c++) begin
      rr = (c == 10); rd = 8'h44;
      step();
      if (tx_trigger) trig++;
      if (!link_error) n++;
    end
    rr = 1'b0;
    chk("error.no_trigger", 32'(trig), 32'd0);
    chk("error.sticky_low_cycles", 32'(n), 32'd0);
    rst = 1'b1;
    #1;
    chk("error.cleared_by_reset", 32'(link_error), 32'd0);
    step();
    rst = 1'b0;

    // Collision: the peer byte is ACKed first, the move follows after the gap.
    mv = 1'b1; mi = 8'h21; rr = 1'b1; rd = 8'h07;
    step();
    mv = 1'b0; rr = 1'b0;
    chk("coll.ack_trigger", 32'(tx_trigger), 32'd1);
    chk("coll.ack_data", 32'(tx_data), 32'hFF);
    chk("coll.peer_valid", 32'(peer_move_valid), 32'd1);
    chk("coll.peer_move", 32'(peer_move), 32'h07);
    wait_trig(100, n);
    chk("coll.move_delay", 32'(n), 32'(F + 2));
    chk("coll.move_data", 32'(tx_data), 32'h21);
    wait_trig(200, n);
    chk("coll.retransmit_spacing", 32'(n), 32'd121);

    // Reset in WAIT_ACK after one retry; the next move gets the full retry budget.
    repeat (F + 10) step();
    chk("rst.busy_before", 32'(link_busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst.tx_trigger", 32'(tx_trigger), 32'd0);
    chk("rst.tx_data", 32'(tx_data), 32'd0);
    chk("rst.peer_move_valid", 32'(peer_move_valid), 32'd0);
    chk("rst.peer_move", 32'(peer_move), 32'd0);
    chk("rst.link_busy", 32'(link_busy), 32'd0);
    chk("rst.link_error", 32'(link_error), 32'd0);
    step();
    rst = 1'b0;
    mv = 1'b1; mi = 8'h55;
    step();
    mv = 1'b0;
    chk("rst.new_trigger", 32'(tx_trigger), 32'd1);
    chk("rst.new_data", 32'(tx_data), 32'h55);
    trig = 0;
    n = 0;
    do begin
      step();
      n++;
      if (tx_trigger) trig++;
    end while (!link_error && n < 600);
    chk("rst.retransmits_after_reset", 32'(trig), 32'd2);
    chk("rst.error_reached", 32'(link_error), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/move_link_ctrl.md
# move_link_ctrl

Reliable-delivery controller for the inter-board move link. It sits between the game FSM and the UART tx/rx pair. It sends each locally accepted move to the peer and retransmits until the peer acknowledges it. It acknowledges each peer move and forwards it to the game FSM exactly once. It gives up and flags an error after a bounded number of retries.

## Interface
Parameters:
- PKT_LEN, 8, move/byte width
- FRAME_CLKS, 67_710, cycles one tx frame occupies the line (10 × DIVISOR at 65 MHz / 9600 baud)
- ACK_TIMEOUT, 65_000_000, cycles to wait for ACK after a frame ends (1 s)
- MAX_RETRIES, 3, retransmissions allowed after the first send
- ACK_BYTE, 8'hFF, reserved link byte; never a legal move

Ports:
- clk_in  in  1  system clock (65 MHz)
- rst_in  in  1  reset, asynchronous, active-high
- move_valid  in  1  one-cycle pulse: local move accepted by the game FSM
- move_in  in  PKT_LEN  local move, sampled when move_valid=1
- rx_ready  in  1  one-cycle pulse from rx: byte received
- rx_data  in  PKT_LEN  received byte, valid when rx_ready=1
- tx_trigger  out  1  one-cycle pulse that starts a tx frame
- tx_data  out  PKT_LEN  byte for tx; held stable between triggers
- peer_move_valid  out  1  one-cycle pulse: new peer move
- peer_move  out  PKT_LEN  peer move; held until the next peer_move_valid
- link_busy  out  1  high in any state other than IDLE and ERROR
- link_error  out  1  retries exhausted; sticky

## Operation
- States: IDLE, SEND_MOVE, WAIT_TX, WAIT_ACK, SEND_ACK, ACK_GAP, ERROR.
- IDLE behaviour:
  - move_valid: latch the move, clear retry_cnt, go to SEND_MOVE.
  - rx_ready with a non-ACK byte: go to SEND_ACK.
  - rx_ready with ACK_BYTE: ignore it.
- SEND_MOVE: pulse tx_trigger with tx_data = latched move, then go to WAIT_TX.
- WAIT_TX: count FRAME_CLKS cycles, then go to WAIT_ACK and load the ACK timer.
- WAIT_ACK:
  - rx_data == ACK_BYTE: set expect_peer=1, go to IDLE.
  - Timer expires with retry_cnt < MAX_RETRIES: increment retry_cnt, go to SEND_MOVE.
  - Timer expires otherwise: go to ERROR.
  - Non-ACK bytes are dropped; the peer retransmits them.
- SEND_ACK:
  - Pulse tx_trigger with tx_data = ACK_BYTE.
  - If expect_peer=1, also pulse peer_move_valid, load peer_move, and clear expect_peer.
  - If expect_peer=0, the byte is a duplicate retransmission (our ACK was lost): re-ACK only, do not forward.
  - Go to ACK_GAP.
- ACK_GAP: count FRAME_CLKS cycles, then go to IDLE.
- ERROR: link_error=1. Only move_valid (a fresh send attempt: clears link_error and retry_cnt, goes to SEND_MOVE) or rst_in leaves it.
- Pending slot (one entry):
  - move_valid in any state other than IDLE/ERROR stores the move in the pending slot.
  - IDLE with the pending slot full behaves as if move_valid had arrived.
  - A second move_valid while the slot is full is dropped.
- Simultaneous move_valid and non-ACK rx_ready in IDLE: the rx byte wins (SEND_ACK); the move goes to the pending slot.
- Reset values: every output 0, state IDLE, expect_peer=1, pending slot empty, retry_cnt=0.
- rst_in mid-frame aborts immediately. The outputs return to their reset values asynchronously.

## Timing
- move_valid at cycle N in IDLE → tx_trigger at N+1.
- First ACK-timer cycle is N+2+FRAME_CLKS.
- Timeout retransmit: tx_trigger one cycle after the timer reaches 0.
- ACK received at cycle M → IDLE at M+1; link_busy low from M+1.
- Peer byte with rx_ready at cycle N in IDLE → tx_trigger (ACK) and peer_move_valid both at N+1.
- Back-to-back tx_trigger pulses are never closer than FRAME_CLKS+1 cycles.
- Counters: FRAME/ACK timer width = $clog2(ACK_TIMEOUT+1); retry_cnt width = $clog2(MAX_RETRIES+1). Neither counter wraps; both saturate at 0 / MAX_RETRIES.

## Structure
- Shared package link_pkg holds the state enum link_state_t and the default ACK_BYTE constant, so the game FSM and the bench use the same reserved code.
- One sub-module: link_timer.
  - Loadable down-counter: inputs load, load_val; output expired, a pulse on reaching 0.
  - Reused for both the FRAME_CLKS gap and the ACK_TIMEOUT wait.

## Test plan
Bench parameters: FRAME_CLKS=20, ACK_TIMEOUT=100, MAX_RETRIES=2.
- Clean send: move_valid, move_in=8'h35 → tx_trigger with 8'h35 one cycle later. Inject ACK_BYTE during WAIT_ACK → IDLE next cycle, link_busy=0, link_error=0.
- Retries exhausted: move_valid 8'h12 with no ACK → exactly 3 tx_trigger pulses carrying 8'h12, spaced 121 cycles apart. Then link_error=1 and link_busy=0, held until rst_in.
- Peer move: rx_ready with 8'h44 in IDLE → next cycle peer_move_valid=1, peer_move=8'h44, tx_trigger with tx_data=8'hFF.
- Duplicate: the same 8'h44 is received again before any local move → ACK is resent, no peer_move_valid.
- Collision: move_valid 8'h21 and rx_ready 8'h07 in the same cycle → ACK sent first. After ACK_GAP, tx_trigger with 8'h21.
- Reset mid-operation: assert rst_in during WAIT_ACK → all outputs 0 immediately. A later move_valid starts from retry_cnt=0.
